serial_adder: RTL and testbench
===============================

// Module: serial_adder
//
// PURPOSE
//   Bit-serial N-bit adder: the sequential consumer of the half-adder stage.
//   Two half adders plus an OR form the one-bit full adder, and a carry flop closes the loop.
//   Operands are captured in parallel and added LSB first, one bit per clock.
//   Result is presented in parallel with a carry-out and a one-cycle done strobe.
//   Datapath building block for the serial ALU path: a small-area alternative to the ripple Add16.
//
// PARAMETERS
//   WIDTH   16   operand/result width in bits (>=2)
//
// PORTS
//   clk     in   1       rising-edge clock
//   rst_n   in   1       asynchronous reset, active low
//   start   in   1       request: capture a/b and begin; honoured only when busy=0
//   a       in   WIDTH   operand A, sampled on the accepting edge only
//   b       in   WIDTH   operand B, sampled on the accepting edge only
//   sub     in   1       only when SERIAL_ADDER_SUB_EN defined: 1 = compute a-b
//   busy    out  1       1 while a serial operation is in progress
//   done    out  1       one-cycle strobe: sum/carry just became final
//   sum     out  WIDTH   result (a+b) mod 2^WIDTH, held until the next completion
//   carry   out  1       carry out of bit WIDTH-1, held with sum
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE; busy, done, sum and carry = 0; internal registers cleared.
//   - FSM states: IDLE, RUN, DONE.
//     - IDLE: start=1 at edge E0 -> RUN. Loads shift regs A/B, bit counter=0, carry flop=0.
//     - RUN: each edge adds A[0]+B[0]+c.
//       - The sum bit shifts into the MSB of the result shift reg; A/B shift right; c <= cout; count++.
//       - On the edge processing bit WIDTH-1 (edge E_WIDTH) -> DONE.
//       - sum/carry output regs load the final values on that same edge.
//     - DONE: done=1 for exactly this cycle.
//       - Next edge: start=1 -> RUN (back-to-back, new operands captured); else -> IDLE.
//   - busy=1 in RUN only. Latency: start-accepting edge to done-high = WIDTH edges.
//   - Throughput: one add per WIDTH+1 cycles.
//   - start while busy=1: ignored, no effect on the operation in flight.
//   - a/b changes during RUN: no effect (operands are captured on the accepting edge).
//   - sum/carry change only on entry to DONE. They are never updated with partial results.
//     - They keep the previous result through IDLE and RUN.
//   - Reset asserted mid-RUN: immediate abort to IDLE, all outputs 0, no done strobe.
//   - The carry chain wraps: overflow sets carry=1 and sum keeps the low WIDTH bits.
//
// CONFIGURATION
//   SERIAL_ADDER_SUB_EN
//     Defined:
//       - sub port exists. sub is sampled with a/b on the accepting edge.
//       - When sub=1: the B shift reg loads ~b and the carry flop initialises to 1, giving a + ~b + 1.
//       - carry=1 means no borrow (a >= b unsigned).
//     Undefined:
//       - No sub port. Carry flop always initialises to 0, giving addition only.
//
// TESTING  (WIDTH=16 unless noted; check values in the done cycle)
//   1. Reset, then start with a=0x0001, b=0x0001
//        -> done exactly 16 edges after the accepting edge; sum=0x0002, carry=0.
//   2. a=0xFFFF, b=0x0001 -> sum=0x0000, carry=1.
//      a=0x1234, b=0x4321 -> sum=0x5555, carry=0.
//      Between completions, sum/carry hold their old values during RUN.
//   3. Pulse start with new operands at cycles 3 and 9 of RUN
//        -> ignored; result equals the first operands; busy stays 1 until DONE.
//   4. Assert rst_n=0 at cycle 7 of RUN -> busy, done, sum, carry = 0 immediately.
//      Release and start a=2, b=3 -> sum=5.
//   5. start held high in the DONE cycle with a=0x00FF, b=0x0101
//        -> RUN entered directly with no IDLE cycle; next done gives sum=0x0200.
//   6. WIDTH=4, exhaustive over all 256 a/b pairs -> {carry,sum} == a+b.
//      With SERIAL_ADDER_SUB_EN: 0x0005-0x0007 -> sum=0xFFFE, carry=0.
//      With SERIAL_ADDER_SUB_EN: 0x0007-0x0005 -> sum=0x0002, carry=1.

Source files
------------

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit adder. Operands are captured in parallel,
//            added LSB first one bit per clock through a full adder built
//            from two half adders and an OR, with a carry flop closing the
//            loop. The result is presented in parallel with a carry-out and
//            a one-cycle done strobe.
// Config   : SERIAL_ADDER_SUB_EN - when defined, adds the sub port; sub=1
//            computes a-b as a + ~b + 1 (carry=1 means no borrow).
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous reset, active low
//            start  - capture a/b and begin (honoured only when not busy)
//            a, b   - operands, sampled on the accepting edge only
//            sub    - (SERIAL_ADDER_SUB_EN only) 1 = subtract
//            busy   - high while a serial operation is in progress
//            done   - one-cycle strobe, sum/carry just became final
//            sum    - result, held until the next completion
//            carry  - carry out of bit WIDTH-1, held with sum
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int             CW    = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic [WIDTH-1:0] w_b_init;
  logic             w_c_init;

  logic             w_ha1_s;
  logic             w_ha1_c;
  logic             w_ha2_s;
  logic             w_ha2_c;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

  // Subtraction reuses the adder: a + ~b + 1, the +1 entering as carry-in.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_init = sub ? ~b : b;
  assign w_c_init = sub;
`else
  assign w_b_init = b;
  assign w_c_init = 1'b0;
`endif

  // Full adder = two half adders plus an OR of their carries.
  assign w_ha1_s    = r_a[0] ^ r_b[0];
  assign w_ha1_c    = r_a[0] & r_b[0];
  assign w_ha2_s    = w_ha1_s ^ r_c;
  assign w_ha2_c    = w_ha1_s & r_c;
  assign w_cout     = w_ha1_c | w_ha2_c;
  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at LSB.
  assign w_res_next = {w_ha2_s, r_res[WIDTH-1:1]};

  assign w_last = (r_cnt == C_LAST);
  // Operands are accepted from IDLE and also straight out of DONE.
  assign w_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= w_b_init;
      r_res <= '0;
      r_cnt <= '0;
      r_c   <= w_c_init;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= w_res_next;
      r_c   <= w_cout;
      r_cnt <= r_cnt + CW'(1);
      // Outputs update only with the final bit, never with partial results.
      if (w_last) begin
        r_sum   <= w_res_next;
        r_carry <= w_cout;
      end
    end
  end

  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign sum   = r_sum;
  assign carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Self-checking bench for serial_adder. A 16-bit instance covers
//            reset, latency, hold behaviour, ignored start, mid-run reset,
//            back-to-back and random operations; a 4-bit instance is swept
//            exhaustively. Subtraction cases are included when
//            SERIAL_ADDER_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [3:0]  sum4;
  logic        carry4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (1'b0),
`endif
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .carry (carry4)
  );

  // Reference: plain 17-bit arithmetic; subtraction as a + ~b + 1.
  function automatic logic [16:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic s);
    logic [15:0] ny;
    ny = ~y;
    if (s) return {1'b0, x} + {1'b0, ny} + 17'd1;
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Runs one 16-bit operation starting at a negedge; returns at the negedge
  // where done is visible (or after the cycle budget). Also reports whether
  // sum/carry held and busy stayed high for the whole run.
  task automatic do_op16(input logic [15:0] x, input logic [15:0] y, input logic s,
                         input bit pulse, output int lat, output bit held, output bit busy_ok);
    logic [15:0] ps;
    logic        pc;
    ps = sum; pc = carry; held = 1'b1; busy_ok = 1'b1; lat = 0;
    start = 1'b1; a = x; b = y;
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`endif
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    while (!done && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (sum !== ps || carry !== pc) held = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      start = pulse && (lat == 3 || lat == 9);
      @(posedge clk); lat++; @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int lat; bit held; bit bok;
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; a = '0; b = '0; a4 = '0; b4 = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #1;
    tests++;
    if ({busy, done, carry, sum} !== 19'd0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", {busy, done, carry, sum});
    end
    @(negedge clk); rst_n = 1'b1;
    do_op16(16'h0001, 16'h0001, 1'b0, 1'b0, lat, held, bok);
    tests++;
    if (lat !== 16) begin fails++; $display("FAIL latency_1p1: got %0d want 16", lat); end
    tests++;
    if ({carry, sum} !== 17'h00002) begin
      fails++; $display("FAIL sum_1p1: got %h want 00002", {carry, sum});
    end
  endtask

  task automatic test_basic();
    logic [15:0] xs [2] = '{16'hFFFF, 16'h1234};
    logic [15:0] ys [2] = '{16'h0001, 16'h4321};
    int lat; bit held; bit bok;
    for (int i = 0; i < 2; i++) begin
      do_op16(xs[i], ys[i], 1'b0, 1'b0, lat, held, bok);
      tests++;
      if ({carry, sum} !== ref_model(xs[i], ys[i], 1'b0)) begin
        fails++;
        $display("FAIL basic_%0d: got %h want %h", i, {carry, sum}, ref_model(xs[i], ys[i], 1'b0));
      end
      tests++;
      if (held !== 1'b1) begin fails++; $display("FAIL hold_%0d: got %0d want 1", i, held); end
    end
  endtask

  task automatic test_start_ignored();
    int lat; bit held; bit bok;
    do_op16(16'h0F0F, 16'h7070, 1'b0, 1'b1, lat, held, bok);
    tests++;
    if ({carry, sum} !== ref_model(16'h0F0F, 16'h7070, 1'b0)) begin
      fails++; $display("FAIL ignore_sum: got %h want %h", {carry, sum}, ref_model(16'h0F0F, 16'h7070, 1'b0));
    end
    tests++;
    if (bok !== 1'b1 || lat !== 16) begin
      fails++; $display("FAIL ignore_busy: got busy_ok=%0d lat=%0d want 1/16", bok, lat);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit held; bit bok;
    start = 1'b1; a = 16'hAAAA; b = 16'h1111;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || sum === 16'h0) begin
      fails++; $display("FAIL pre_abort: got busy=%0d sum=%h want busy=1 sum!=0", busy, sum);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, carry, sum} !== 19'd0) begin
      fails++; $display("FAIL abort_outputs: got %h want 0", {busy, done, carry, sum});
    end
    @(posedge clk); @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++; $display("FAIL abort_strobe: got %b want 00", {busy, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_op16(16'd2, 16'd3, 1'b0, 1'b0, lat, held, bok);
    tests++;
    if ({carry, sum} !== 17'd5) begin
      fails++; $display("FAIL after_abort: got %h want 00005", {carry, sum});
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit held; bit bok;
    do_op16(16'h1111, 16'h2222, 1'b0, 1'b0, lat, held, bok);
    // Still in the done cycle: start again immediately.
    do_op16(16'h00FF, 16'h0101, 1'b0, 1'b0, lat, held, bok);
    tests++;
    if (lat !== 16 || bok !== 1'b1) begin
      fails++; $display("FAIL b2b_timing: got lat=%0d busy_ok=%0d want 16/1", lat, bok);
    end
    tests++;
    if ({carry, sum} !== 17'h00200) begin
      fails++; $display("FAIL b2b_sum: got %h want 00200", {carry, sum});
    end
  endtask

  task automatic test_random();
    int lat; bit held; bit bok;
    logic [15:0] x;
    logic [15:0] y;
    logic        s;
    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom); y = 16'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      if (i == 0) begin x = 16'h8000; y = 16'h8000; end
      do_op16(x, y, s, 1'($urandom), lat, held, bok);
      tests++;
      if ({carry, sum} !== ref_model(x, y, s) || lat !== 16 || held !== 1'b1) begin
        fails++;
        $display("FAIL random_%0d: got %h lat=%0d held=%0d want %h lat=16 held=1",
                 i, {carry, sum}, lat, held, ref_model(x, y, s));
      end
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat; bit held; bit bok;
    do_op16(16'h0005, 16'h0007, 1'b1, 1'b0, lat, held, bok);
    tests++;
    if ({carry, sum} !== 17'h0FFFE) begin
      fails++; $display("FAIL sub_5m7: got %h want 0FFFE", {carry, sum});
    end
    do_op16(16'h0007, 16'h0005, 1'b1, 1'b0, lat, held, bok);
    tests++;
    if ({carry, sum} !== 17'h10002) begin
      fails++; $display("FAIL sub_7m5: got %h want 10002", {carry, sum});
    end
  endtask
`endif

  task automatic test_exhaustive4();
    int lat;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        start4 = 1'b1; a4 = 4'(i); b4 = 4'(j);
        @(posedge clk); @(negedge clk);
        start4 = 1'b0; lat = 0;
        while (!done4 && lat < 50) begin
          a4 = 4'($urandom); b4 = 4'($urandom);
          @(posedge clk); lat++; @(negedge clk);
        end
        tests++;
        if ({carry4, sum4} !== 5'(i + j) || lat !== 4) begin
          fails++;
          $display("FAIL exh4_%0d_%0d: got %h lat=%0d want %h lat=4", i, j, {carry4, sum4}, lat, 5'(i + j));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_exhaustive4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
